dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Responder side of the memory-FU load/store interface. Accepts one load at a time from the memory FU,
//   returns data after LAT cycles on the writeback channel, and applies retired stores from the LSQ.
// - Sits between the memory FU/LSQ and the word-addressed data array; owns the array, byte lanes,
//   sign extension and mispredict squash of the in-flight load.
// PARAMETERS
// - DEPTH  1024  number of 32-bit words; power of two; AW = $clog2(DEPTH)
// - LAT    2     load latency in cycles from accept to resp_valid; legal range 1..15
// PORTS
// - clk            in   1   single clock; all state on posedge
// - reset          in   1   asynchronous, active-high
// - ld_valid       in   1   load request offered
// - ld_ready       out  1   responder can accept a load (state IDLE)
// - ld_addr        in   32  byte address (ps1 + imm)
// - ld_funct3      in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
// - ld_pd          in   7   destination physical register
// - ld_rob         in   5   ROB tag of load
// - st_valid       in   1   retired store writeback from LSQ; always accepted, no ready
// - st_addr        in   32  byte address
// - st_wdata       in   32  store data (ps2), low-aligned
// - st_funct3      in   3   000 SB, 001 SH, 010 SW; others treated as SW
// - mispredict     in   1   branch squash strobe
// - mispredict_tag in   5   ROB tag of mispredicted branch
// - curr_rob_tag   in   5   ROB tail (next allocated tag)
// - resp_valid     out  1   one-cycle load completion pulse
// - resp_pd        out  7   echoed ld_pd
// - resp_rob       out  5   echoed ld_rob
// - resp_data      out  32  extended load data
// - resp_err       out  1   misaligned load flag (DMEM_MISALIGN_CHK_EN only; else tied 0)
// BEHAVIOUR
// - Reset (async): state=IDLE, counter=0, ld_ready=1, resp_* all 0. Array contents NOT reset.
// - Word index = addr[AW+1:2]; upper address bits ignored (aliasing wraps); byte lane = addr[1:0].
// - FSM IDLE -> WAIT -> RESP -> IDLE. Accept = ld_valid && ld_ready.
//   - IDLE: on accept latch pd/rob/funct3/lane and read array word in the same cycle (read-before-write).
//     Goes to WAIT with cnt=LAT-1, or straight to RESP when LAT==1.
//   - WAIT: cnt decrements each cycle; at cnt==1 go to RESP.
//   - RESP: resp_valid=1 with latched fields for exactly one cycle; next state IDLE.
//   - Result: accept at cycle t -> resp_valid at cycle t+LAT. ld_ready=0 in WAIT and RESP.
//   - Throughput: one load per LAT+1 cycles.
// - Extension: LB/LH sign-extend the selected byte/halfword; LBU/LHU zero-extend.
//   - LH/LHU lane uses addr[1] only; LW ignores addr[1:0].
// - Stores: st_valid writes the array at posedge with byte enables. SB: 1 lane from addr[1:0],
//   SH: 2 lanes from addr[1], SW: all 4 lanes. Data replicated to lanes from st_wdata[7:0]/[15:0].
// - Same-cycle load accept and store to same word: load captures OLD data. Store after accept
//   never affects the latched load data; ordering is the LSQ's job.
// - Squash: a held load (WAIT or RESP) is flushed when mispredict=1 and its rob lies in the circular range
//   starting at (mispredict_tag==15 ? 0 : mispredict_tag+1), stepping 15->0, up to but excluding curr_rob_tag.
//   - Flush: state -> IDLE next cycle, and resp_valid is forced 0 in that cycle, including when RESP coincides.
//   - A load offered in the mispredict cycle is not accepted (ld_ready=0 while mispredict=1).
//   - Stores are never squashed. Loads outside the range proceed normally.
// - Reset mid-operation: the in-flight load is discarded and no response is emitted.
// CONFIGURATION
// - DMEM_MISALIGN_CHK_EN defined: LH/LHU with addr[0]=1 or LW with addr[1:0]!=0 sets resp_err=1 in the
//   RESP cycle; resp_data=0 for that load. Misaligned stores are dropped: no array write.
// - Undefined: resp_err tied 0; low address bits truncated as above; no access is dropped.
// TESTING
// - SW 0xDEADBEEF @0x10, then LW @0x10 (pd=5,rob=3), LAT=2 -> resp_valid at accept+2, data 0xDEADBEEF, pd 5, rob 3.
// - Same word: LB @0x11 -> 0xFFFFFFBE; LBU @0x11 -> 0x000000BE; LH @0x12 -> 0xFFFFDEAD; LHU @0x12 -> 0x0000DEAD.
// - SB 0x77 @0x13 in the same cycle as LW @0x10 is accepted -> load returns 0xDEADBEEF; next LW -> 0x77ADBEEF.
// - Load rob=6 in WAIT, mispredict_tag=4, curr_rob_tag=9 -> no resp_valid, ld_ready=1 next cycle.
//   Repeat with mispredict_tag=14, curr_rob_tag=2 (range 15,0,1) and load rob=0 -> squashed; load rob=6 -> completes.
// - Assert reset during WAIT -> resp_* 0 immediately, ld_ready=1; prior array data at 0x10 still readable.
// - DMEM_MISALIGN_CHK_EN: LW @0x12 -> resp_err=1, resp_data=0; SH @0x11 leaves word unchanged.

Source files
------------

// File: rtl/dmem_if.sv
// Load/store/writeback bundle between the memory FU/LSQ (master) and dmem_responder (slave).
// ld_valid/ld_ready: a load transfers on a clock edge where both are high; st_valid has no ready
// and always transfers; resp_valid is a one-cycle pulse with no back-pressure.
interface dmem_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [6:0]  ld_pd;
  logic [4:0]  ld_rob;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [2:0]  st_funct3;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic [4:0]  curr_rob_tag;
  logic        resp_valid;
  logic [6:0]  resp_pd;
  logic [4:0]  resp_rob;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output ld_valid, ld_addr, ld_funct3, ld_pd, ld_rob,
    output st_valid, st_addr, st_wdata, st_funct3,
    output mispredict, mispredict_tag, curr_rob_tag,
    input  ld_ready, resp_valid, resp_pd, resp_rob, resp_data, resp_err
  );

  modport slave (
    input  ld_valid, ld_addr, ld_funct3, ld_pd, ld_rob,
    input  st_valid, st_addr, st_wdata, st_funct3,
    input  mispredict, mispredict_tag, curr_rob_tag,
    output ld_ready, resp_valid, resp_pd, resp_rob, resp_data, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load in flight with LAT-cycle latency, byte-enabled stores, squash.
// Optional macro DMEM_MISALIGN_CHK_EN flags misaligned loads (resp_err) and drops misaligned stores.
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [6:0]  hold_pd;
  logic [4:0]  hold_rob;
  logic [31:0] hold_data;
  logic        hold_err;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          flush;
  logic [31:0]   rd_word;
  logic          ld_mis;
  logic          st_mis;
  logic [AW-1:0] st_idx;
  logic [3:0]    st_be;
  logic [31:0]   st_rep;
  logic [3:0]    sq_start;
  logic [3:0]    sq_dist_rob;
  logic [3:0]    sq_dist_cur;
  logic          unused_bits;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'd0, b};
      3'b101:  extend = {16'd0, h};
      default: extend = w;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_CHK_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] low);
    case (f3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = low[0];
      default:        misaligned = (low != 2'b00);
    endcase
  endfunction

  // Stores never use 100/101 as halfword codes, so those fall into the word case.
  assign ld_mis = misaligned(bus.ld_funct3, bus.ld_addr[1:0]);
  assign st_mis = (bus.st_funct3 == 3'b100 || bus.st_funct3 == 3'b101) ?
                  (bus.st_addr[1:0] != 2'b00) : misaligned(bus.st_funct3, bus.st_addr[1:0]);
`else
  assign ld_mis = 1'b0;
  assign st_mis = 1'b0;
`endif

  assign rd_word   = mem[bus.ld_addr[AW+1:2]];
  assign accept    = bus.ld_valid && bus.ld_ready;
  assign dbg_state = state;

  // Squash window starts one past the branch tag and runs up to (excluding) the ROB tail, mod 16.
  always_comb begin
    sq_start    = bus.mispredict_tag[3:0] + 4'd1;
    sq_dist_rob = hold_rob[3:0] - sq_start;
    sq_dist_cur = bus.curr_rob_tag[3:0] - sq_start;
    flush       = bus.mispredict && (state != S_IDLE) && (sq_dist_rob < sq_dist_cur);
  end

  assign bus.ld_ready   = (state == S_IDLE) && !bus.mispredict;
  assign bus.resp_valid = (state == S_RESP) && !flush;
  assign bus.resp_pd    = bus.resp_valid ? hold_pd   : 7'd0;
  assign bus.resp_rob   = bus.resp_valid ? hold_rob  : 5'd0;
  assign bus.resp_data  = bus.resp_valid ? hold_data : 32'd0;
  assign bus.resp_err   = bus.resp_valid ? hold_err  : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      hold_pd   <= 7'd0;
      hold_rob  <= 5'd0;
      hold_data <= 32'd0;
      hold_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            hold_pd   <= bus.ld_pd;
            hold_rob  <= bus.ld_rob;
            hold_data <= ld_mis ? 32'd0 : extend(rd_word, bus.ld_funct3, bus.ld_addr[1:0]);
            hold_err  <= ld_mis;
            if (LAT == 1) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(LAT - 1);
            end
          end
        end
        S_WAIT: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    st_idx = bus.st_addr[AW+1:2];
    case (bus.st_funct3)
      3'b000: begin
        st_be  = 4'b0001 << bus.st_addr[1:0];
        st_rep = {4{bus.st_wdata[7:0]}};
      end
      3'b001: begin
        st_be  = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        st_rep = {2{bus.st_wdata[15:0]}};
      end
      default: begin
        st_be  = 4'b1111;
        st_rep = bus.st_wdata;
      end
    endcase
  end

  // Array has no reset; the load read above sees pre-store contents in a same-edge collision.
  always_ff @(posedge clk) begin
    if (bus.st_valid && !st_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[st_idx][8*i +: 8] <= st_rep[8*i +: 8];
      end
    end
  end

  assign unused_bits = ^{bus.ld_addr[31:AW+2], bus.st_addr[31:AW+2],
                         bus.mispredict_tag[4], bus.curr_rob_tag[4]};
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases then random loads/stores/squashes
// against a byte-level memory model; a negedge monitor checks every response.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  dmem_if     bus ();

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [44:0] exp_q [$];
  int          exp_t_q [$];
  bit          held = 1'b0;
  int          held_k = 0;
  logic [4:0]  held_rob = 5'd0;
  int          free_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Walk the squash window one tag at a time, 15 wrapping to 0.
  function automatic bit in_squash_range(input logic [4:0] rob, input logic [4:0] mt,
                                         input logic [4:0] ct);
    int t;
    t = (mt == 15) ? 0 : mt + 1;
    for (int n = 0; n < 16; n++) begin
      if (t == int'(ct)) return 1'b0;
      if (t == int'(rob)) return 1'b1;
      t = (t == 15) ? 0 : t + 1;
    end
    return 1'b0;
  endfunction

  function automatic logic [44:0] model_load(input logic [31:0] addr, input logic [2:0] f3,
                                             input logic [6:0] pd, input logic [4:0] rob);
    logic [31:0] word, byte_v, half_v, data;
    logic        err;
    word   = ref_mem[(addr >> 2) % DEPTH];
    byte_v = (word >> ((addr % 4) * 8)) & 32'hFF;
    half_v = (word >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    data = byte_v + ((byte_v >= 128) ? 32'hFFFFFF00 : 32'd0);
      3'd1:    data = half_v + ((half_v >= 32768) ? 32'hFFFF0000 : 32'd0);
      3'd4:    data = byte_v;
      3'd5:    data = half_v;
      default: data = word;
    endcase
    err = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) err = 1'b1;
    if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) && (addr % 4 != 0)) err = 1'b1;
    if (err) data = 32'd0;
`endif
    return {err, pd, rob, data};
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] f3);
    int          idx, sh;
    logic [31:0] mask;
    idx = (addr >> 2) % DEPTH;
    if (f3 == 3'd0) begin
      sh = (addr % 4) * 8; mask = 32'hFF << sh;
    end else if (f3 == 3'd1) begin
      sh = ((addr / 2) % 2) * 16; mask = 32'hFFFF << sh;
`ifdef DMEM_MISALIGN_CHK_EN
      if (addr % 2 != 0) return;
`endif
    end else begin
      sh = 0; mask = 32'hFFFFFFFF;
`ifdef DMEM_MISALIGN_CHK_EN
      if (addr % 4 != 0) return;
`endif
    end
    ref_mem[idx] = (ref_mem[idx] & ~mask) | ((data << sh) & mask);
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic drive_cycle(input bit lv, input logic [31:0] la, input logic [2:0] lf,
                             input logic [6:0] lpd, input logic [4:0] lrob,
                             input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                             input logic [2:0] sf,
                             input bit mp, input logic [4:0] mt, input logic [4:0] ct);
    bit exp_rdy;
    bus.ld_valid = lv; bus.ld_addr = la; bus.ld_funct3 = lf; bus.ld_pd = lpd; bus.ld_rob = lrob;
    bus.st_valid = sv; bus.st_addr = sa; bus.st_wdata = sd; bus.st_funct3 = sf;
    bus.mispredict = mp; bus.mispredict_tag = mt; bus.curr_rob_tag = ct;
    #2;
    if (held && cyc > held_k + LAT) held = 1'b0;
    if (held && mp && in_squash_range(held_rob, mt, ct)) begin
      held = 1'b0;
      free_cyc = cyc + 1;
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_back());
        void'(exp_t_q.pop_back());
      end
    end
    exp_rdy = (cyc >= free_cyc) && !mp;
    check("ld_ready", 64'(bus.ld_ready), 64'(exp_rdy));
    if (lv && exp_rdy) begin
      exp_q.push_back(model_load(la, lf, lpd, lrob));
      exp_t_q.push_back(cyc + LAT);
      held = 1'b1; held_k = cyc; held_rob = lrob; free_cyc = cyc + LAT + 1;
    end
    if (sv) model_store(sa, sd, sf);
    @(posedge clk); #1;
    bus.ld_valid = 1'b0; bus.st_valid = 1'b0; bus.mispredict = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f, input logic [6:0] pd,
                      input logic [4:0] rob);
    drive_cycle(1, a, f, pd, rob, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    drive_cycle(0, 0, 0, 0, 0, 1, a, d, f, 0, 0, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_resp_fields"}, {bus.resp_err, bus.resp_pd, bus.resp_rob, bus.resp_data}, 64'd0);
    check({tag, "_ld_ready"}, 64'(bus.ld_ready), 64'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    check_quiet("reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete(); exp_t_q.delete();
    held = 1'b0; free_cyc = cyc;
  endtask

  // Monitor: every response must match the oldest expectation at its predicted cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual rob=%0d data=%h expected none", bus.resp_rob,
                   bus.resp_data);
        end else begin
          check("resp_cycle", 64'(cyc), 64'(exp_t_q.pop_front()));
          check("resp_fields", {bus.resp_err, bus.resp_pd, bus.resp_rob, bus.resp_data},
                64'(exp_q.pop_front()));
        end
      end else if (exp_t_q.size() > 0 && exp_t_q[0] <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_resp actual none expected=%h at cycle %0d", exp_q[0], exp_t_q[0]);
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    int w, idx;
    w   = $urandom_range(0, 15);
    idx = (w < 8) ? w : 1008 + w;
    return ($urandom() & 32'hFFFFF000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_funct3 = 0; bus.ld_pd = 0; bus.ld_rob = 0;
    bus.st_valid = 0; bus.st_addr = 0; bus.st_wdata = 0; bus.st_funct3 = 0;
    bus.mispredict = 0; bus.mispredict_tag = 0; bus.curr_rob_tag = 0;
    #3;
    check_quiet("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    free_cyc = cyc;

    for (int i = 0; i < 8; i++) begin
      store(32'(i * 4), $urandom(), 3'd2);
      store(32'((1016 + i) * 4), $urandom(), 3'd2);
    end

    store(32'h10, 32'hDEADBEEF, 3'd2);
    load(32'h10, 3'd2, 7'd5, 5'd3);  idle(LAT);
    load(32'h11, 3'd0, 7'd6, 5'd4);  idle(LAT);
    load(32'h11, 3'd4, 7'd7, 5'd5);  idle(LAT);
    load(32'h12, 3'd1, 7'd8, 5'd6);  idle(LAT);
    load(32'h12, 3'd5, 7'd9, 5'd7);  idle(LAT);
    load(32'h1000_0010, 3'd2, 7'd10, 5'd8); idle(LAT);

    // Same-edge store must not leak into the accepted load.
    drive_cycle(1, 32'h10, 3'd2, 7'd11, 5'd9, 1, 32'h13, 32'h0000_0077, 3'd0, 0, 0, 0);
    idle(LAT);
    load(32'h10, 3'd2, 7'd12, 5'd10); idle(LAT);

    load(32'h10, 3'd2, 7'd13, 5'd6);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 5'd9);
    idle(1);
    load(32'h10, 3'd2, 7'd14, 5'd0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd14, 5'd2);
    idle(1);
    load(32'h10, 3'd2, 7'd15, 5'd6);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd14, 5'd2);
    idle(LAT);
    // Squash landing on the response cycle itself.
    load(32'h10, 3'd2, 7'd16, 5'd0);
    idle(LAT - 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd15, 5'd3);
    idle(1);
    // Load offered during a mispredict is refused.
    drive_cycle(1, 32'h10, 3'd2, 7'd17, 5'd1, 0, 0, 0, 0, 1, 5'd1, 5'd2);
    idle(1);

    load(32'h10, 3'd2, 7'd18, 5'd1);
    pulse_reset();
    load(32'h10, 3'd2, 7'd19, 5'd2); idle(LAT);

`ifdef DMEM_MISALIGN_CHK_EN
    load(32'h12, 3'd2, 7'd20, 5'd3); idle(LAT);
    store(32'h11, 32'h0000_1234, 3'd1);
    load(32'h10, 3'd2, 7'd21, 5'd4); idle(LAT);
`endif

    for (int i = 0; i < 500; i++) begin
      drive_cycle($urandom_range(0, 1), rand_addr(), 3'($urandom_range(0, 7)),
                  7'($urandom()), 5'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 3), rand_addr(), $urandom(),
                  3'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)));
    end

    idle(LAT + 3);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
